mux_nto1_rr: RTL and testbench
==============================

Name: mux_nto1_rr

Overview:
- Parametrised N-channel, W-bit registered multiplexer with valid/ready handshaking on every input channel and on the output.
- Two selection modes: fixed select, where an external select picks the channel, and round-robin, where the block scans the valid channels fairly.
- The output is registered, carries the source channel index, and back-pressures upstream when downstream stalls.
- Sits between multiple producer streams and a single consumer, replacing the combinational 4:1 data muxes in datapaths that need flow control.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(CHANNELS), width of the select and channel-index fields; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel select, used in mode 0 only.
- in_data  input  CHANNELS*WIDTH  flattened inputs; channel i at [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready (combinational).
- out_data  output  WIDTH  registered selected data.
- out_chan  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  output register holds valid data.
- out_ready  input  1  downstream accepts out_data.

Behaviour:
- Reset values (asynchronous on rst_n low, released synchronously):
  - out_valid = 0, out_data = 0, out_chan = 0.
  - Internal round-robin pointer ptr = 0.
  - in_ready = 0 while in reset.
- Load enable: load_en = !out_valid || out_ready. Same-cycle drain and refill is allowed, giving full throughput of one word per cycle.
- Grant, mode 0:
  - grant_valid = (sel < CHANNELS) && in_valid[sel]; g = sel.
  - An out-of-range sel (non-power-of-2 CHANNELS) gives no grant. No error is flagged.
- Grant, mode 1:
  - g is the first i with in_valid[i] set, searching ptr, ptr+1, … CHANNELS-1, 0, … ptr-1 (wrap-around).
  - grant_valid = |in_valid.
- Handshake:
  - in_ready[i] = load_en && grant_valid && (g == i). At most one bit is set per cycle.
  - A transfer occurs on channel g when in_valid[g] && in_ready[g].
- Clock edge, when load_en && grant_valid:
  - out_data <= in_data[g]; out_chan <= g; out_valid <= 1.
  - ptr <= (g == CHANNELS-1) ? 0 : g+1. ptr updates in both modes.
- Clock edge, when load_en && !grant_valid: out_valid <= 0; out_data and out_chan hold.
- Clock edge, when !load_en (stall): out_data, out_chan, out_valid and ptr all hold; in_ready is all zero.
- Latency: 1 cycle from input transfer to out_valid.
- Fairness (mode 1): with all channels continuously valid and no stall, the grant sequence is 0,1,…,CHANNELS-1,0,… Maximum wait for any valid channel is CHANNELS-1 transfers.
- Mode or sel changes are sampled combinationally and take effect on the next grant. They never corrupt a word already held in the output register.
- Input data need not be stable while in_ready is low. Downstream must see out_data stable while out_valid && !out_ready.
- Reset mid-operation: the held word is discarded, out_valid drops immediately, ptr returns to 0, and no transfer is reported.
- No combinational path from out_ready to out_data, out_valid or out_chan. in_ready depends combinationally on out_ready, in_valid, mode and sel.

Test Plan:
- Reset/idle: assert rst_n=0 mid-transfer with out_valid=1 -> out_valid=0, out_data=0, out_chan=0 asynchronously. After release with in_valid=0 -> in_ready=0, out_valid stays 0.
- Fixed select: WIDTH=8, CHANNELS=4, mode=0, sel=2, in_data ch2=8'hA5, all in_valid=1, out_ready=1 -> only in_ready[2]=1. Next cycle out_data=8'hA5, out_chan=2, out_valid=1. Change sel to 3 with ch3=8'h3C -> following cycle out_data=8'h3C, out_chan=3.
- Round-robin fairness: mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3. Then in_valid=4'b1010 -> grants alternate 1,3,1,3 with wrap-around.
- Back-pressure: out_valid=1 with out_data=8'h11, hold out_ready=0 for 3 cycles while inputs change -> out_data stays 8'h11, in_ready=0, ptr unchanged. Raise out_ready -> 8'h11 is accepted and the next word loads in the same cycle.
- Drain to empty: single word in flight, then in_valid=0 and out_ready=1 -> out_valid falls after one cycle, out_data holds its last value.
- Parameter sweep: CHANNELS=3, WIDTH=16, mode=0, sel=3 -> no grant, in_ready=0, out_valid=0. Mode=1 with only ch2 valid -> out_chan=2, then ptr wraps to 0.

Source files
------------

// File: rtl/mux_nto1_rr.sv
// N-channel registered multiplexer with valid/ready flow control on every
// input and on the output; fixed-select or round-robin channel selection.

module mux_nto1_rr_lane #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2,
    parameter int IDX   = 0
) (
    input  logic [SEL_W-1:0] g,
    input  logic             fire,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic [WIDTH-1:0] data_m
);
    // Each lane only drives its data onto the AND-OR bus while it holds the grant.
    assign ready  = fire && (g == SEL_W'(IDX));
    assign data_m = ready ? data : '0;
endmodule

module mux_nto1_rr #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);
    localparam int               NPAD = 1 << SEL_W;
    localparam logic [SEL_W:0]   CH_L = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0]                ptr;
    logic [NPAD-1:0]                 valid_pad;
    logic                            fixed_ok;
    logic [SEL_W-1:0]                rr_g;
    logic [SEL_W:0]                  idx;
    logic [SEL_W-1:0]                g;
    logic                            grant_valid;
    logic                            load_en;
    logic                            fire;
    logic [CHANNELS-1:0][WIDTH-1:0]  data_m;
    logic [WIDTH-1:0]                sel_data;

    assign load_en = !out_valid || out_ready;

    // Fixed select: the padded valid vector reads zero for an out-of-range sel.
    always_comb begin
        valid_pad                 = '0;
        valid_pad[CHANNELS-1:0]   = in_valid;
        fixed_ok                  = ({1'b0, sel} < CH_L) && valid_pad[sel];
    end

    // Round-robin: scan offsets from the far end so the nearest hit to ptr wins.
    always_comb begin
        rr_g = ptr;
        idx  = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (SEL_W+1)'(k);
            if (idx >= CH_L)
                idx = idx - CH_L;
            if (in_valid[idx[SEL_W-1:0]])
                rr_g = idx[SEL_W-1:0];
        end
    end

    assign g           = mode ? rr_g : sel;
    assign grant_valid = mode ? |in_valid : fixed_ok;
    // rst_n gates the handshake so nothing is offered upstream while in reset.
    assign fire        = rst_n && load_en && grant_valid;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        mux_nto1_rr_lane #(
            .WIDTH (WIDTH),
            .SEL_W (SEL_W),
            .IDX   (i)
        ) u_lane (
            .g      (g),
            .fire   (fire),
            .data   (in_data[i*WIDTH +: WIDTH]),
            .ready  (in_ready[i]),
            .data_m (data_m[i])
        );
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++)
            sel_data = sel_data | data_m[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_chan  <= g;
                ptr       <= (g == LAST) ? '0 : g + 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux_nto1_rr.sv
// Directed bench for mux_nto1_rr: a 4x8 instance for the main plan and a
// 3x16 instance for out-of-range select and pointer wrap.

module tb_mux_nto1_rr;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // 4-channel, 8-bit instance
    logic        a_mode;
    logic [1:0]  a_sel;
    logic [31:0] a_data;
    logic [3:0]  a_valid;
    logic [3:0]  a_in_ready;
    logic [7:0]  a_out_data;
    logic [1:0]  a_out_chan;
    logic        a_out_valid;
    logic        a_out_ready;

    // 3-channel, 16-bit instance
    logic        b_mode;
    logic [1:0]  b_sel;
    logic [47:0] b_data;
    logic [2:0]  b_valid;
    logic [2:0]  b_in_ready;
    logic [15:0] b_out_data;
    logic [1:0]  b_out_chan;
    logic        b_out_valid;
    logic        b_out_ready;

    mux_nto1_rr #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (a_mode),
        .sel       (a_sel),
        .in_data   (a_data),
        .in_valid  (a_valid),
        .in_ready  (a_in_ready),
        .out_data  (a_out_data),
        .out_chan  (a_out_chan),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready)
    );

    mux_nto1_rr #(.WIDTH(16), .CHANNELS(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (b_mode),
        .sel       (b_sel),
        .in_data   (b_data),
        .in_valid  (b_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_chan  (b_out_chan),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int ch, input logic [7:0] v);
        a_data[ch*8 +: 8] = v;
    endtask

    int rr_exp [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int alt_exp[4] = '{1, 3, 1, 3};

    initial begin
        rst_n = 1'b0;
        a_mode = 1'b0; a_sel = 2'd0; a_data = '0; a_valid = 4'b1111; a_out_ready = 1'b1;
        b_mode = 1'b0; b_sel = 2'd0; b_data = '0; b_valid = 3'b000;  b_out_ready = 1'b1;

        // Reset: outputs cleared and no ready even with valid inputs
        step(); step();
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_data",  32'(a_out_data),  32'd0);
        check("rst_out_chan",  32'(a_out_chan),  32'd0);
        check("rst_in_ready",  32'(a_in_ready),  32'd0);

        // Fixed select
        a_valid = 4'b0000;
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", 32'(a_in_ready), 32'd0);
        step();
        check("idle_out_valid", 32'(a_out_valid), 32'd0);
        set_a(0, 8'h10); set_a(1, 8'h20); set_a(2, 8'hA5); set_a(3, 8'h3C);
        a_valid = 4'b1111; a_sel = 2'd2;
        #1;
        check("fix_in_ready_s2", 32'(a_in_ready), 32'b0100);
        step();
        check("fix_data_s2",  32'(a_out_data),  32'hA5);
        check("fix_chan_s2",  32'(a_out_chan),  32'd2);
        check("fix_valid_s2", 32'(a_out_valid), 32'd1);
        a_sel = 2'd3;
        #1;
        check("fix_in_ready_s3", 32'(a_in_ready), 32'b1000);
        step();
        check("fix_data_s3", 32'(a_out_data), 32'h3C);
        check("fix_chan_s3", 32'(a_out_chan), 32'd3);

        // Round-robin fairness (ptr is 0 after granting ch3)
        a_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("rr_chan", 32'(a_out_chan), 32'(rr_exp[i]));
        end
        a_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_alt_chan", 32'(a_out_chan), 32'(alt_exp[i]));
        end

        // Back-pressure: load 8'h11 from ch1 (ptr becomes 2)
        a_mode = 1'b0; a_sel = 2'd1; a_valid = 4'b1111; set_a(1, 8'h11);
        step();
        check("bp_load_data", 32'(a_out_data), 32'h11);
        a_out_ready = 1'b0;
        a_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_a(0, 8'(8'h50 + i)); set_a(1, 8'(8'h60 + i)); set_a(3, 8'(8'h70 + i));
            #1;
            check("bp_in_ready", 32'(a_in_ready), 32'd0);
            step();
            check("bp_hold_data",  32'(a_out_data),  32'h11);
            check("bp_hold_valid", 32'(a_out_valid), 32'd1);
            check("bp_hold_chan",  32'(a_out_chan),  32'd1);
        end
        set_a(2, 8'h22);
        a_out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(a_in_ready), 32'b0100);
        step();
        check("bp_refill_data", 32'(a_out_data), 32'h22);
        check("bp_refill_chan", 32'(a_out_chan), 32'd2);

        // Drain to empty
        a_valid = 4'b0000;
        #1;
        check("drain_in_ready", 32'(a_in_ready), 32'd0);
        step();
        check("drain_valid", 32'(a_out_valid), 32'd0);
        check("drain_data",  32'(a_out_data),  32'h22);
        check("drain_chan",  32'(a_out_chan),  32'd2);

        // Reset mid-operation while a word is held (ptr becomes 1 before reset)
        a_mode = 1'b0; a_sel = 2'd0; a_valid = 4'b0001; set_a(0, 8'h77);
        step();
        check("mid_load_valid", 32'(a_out_valid), 32'd1);
        a_out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid",    32'(a_out_valid), 32'd0);
        check("mid_rst_data",     32'(a_out_data),  32'd0);
        check("mid_rst_chan",     32'(a_out_chan),  32'd0);
        check("mid_rst_in_ready", 32'(a_in_ready),  32'd0);
        step();
        rst_n = 1'b1; a_valid = 4'b0000; a_out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(a_in_ready), 32'd0);
        step();
        check("post_rst_valid", 32'(a_out_valid), 32'd0);
        a_mode = 1'b1; a_valid = 4'b1111;
        #1;
        check("post_rst_ptr", 32'(a_in_ready), 32'b0001);
        a_valid = 4'b0000;

        // CHANNELS=3, WIDTH=16: out-of-range select, then wrap
        b_mode = 1'b0; b_sel = 2'd3; b_valid = 3'b111;
        b_data = {16'hC2C2, 16'hB1B1, 16'hA0A0};
        #1;
        check("c3_sel3_ready", 32'(b_in_ready), 32'd0);
        step();
        check("c3_sel3_valid", 32'(b_out_valid), 32'd0);
        b_mode = 1'b1; b_valid = 3'b100;
        #1;
        check("c3_rr_ready", 32'(b_in_ready), 32'b100);
        step();
        check("c3_rr_chan",  32'(b_out_chan),  32'd2);
        check("c3_rr_data",  32'(b_out_data),  32'hC2C2);
        check("c3_rr_valid", 32'(b_out_valid), 32'd1);
        b_valid = 3'b111;
        #1;
        check("c3_wrap_ready", 32'(b_in_ready), 32'b001);
        step();
        check("c3_wrap_chan", 32'(b_out_chan), 32'd0);
        check("c3_wrap_data", 32'(b_out_data), 32'hA0A0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
